// File: rtl/fp16_accum.sv
// FP16 (1/5/10, bias 15) sequential accumulator: each accepted product is added into
// acc through an align/add/normalize FSM; full flags a complete dot product.
module fp16_accum #(
    parameter int N_TERMS = 8,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [15:0]      f_in,
    input  logic             v_in,
    output logic             busy,
    output logic             done,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic [15:0]      acc,
    output logic             v
);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, WRITE} state_t;

    state_t           state_reg;
    logic [15:0]      opnd_reg;
    logic [15:0]      acc_reg;
    logic [15:0]      result_reg;
    logic [CNT_W-1:0] count_reg;
    logic             done_reg;
    logic             full_reg;
    logic             v_reg;
    logic             big_sign_reg;
    logic             sub_reg;
    logic [5:0]       exp_reg;
    logic [11:0]      big_mant_reg;
    logic [11:0]      small_mant_reg;
    logic [11:0]      sum_reg;

    // Operand decode and alignment: exp==0 means zero, no subnormals.
    logic [4:0]  a_exp, b_exp, big_exp_next, small_exp_next, diff_next;
    logic [10:0] a_mant, b_mant;
    logic [11:0] big_mant_next, small_mant_next;
    logic        big_sign_next;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        a_exp  = acc_reg[14:10];
        b_exp  = opnd_reg[14:10];
        a_mant = (a_exp == 5'd0) ? 11'd0 : {1'b1, acc_reg[9:0]};
        b_mant = (b_exp == 5'd0) ? 11'd0 : {1'b1, opnd_reg[9:0]};
        if ({b_exp, b_mant} > {a_exp, a_mant}) begin
            big_sign_next  = opnd_reg[15];
            big_exp_next   = b_exp;
            big_mant_next  = {1'b0, b_mant};
            small_exp_next = a_exp;
            small_mant_next = {1'b0, a_mant};
        end else begin
            big_sign_next  = acc_reg[15];
            big_exp_next   = a_exp;
            big_mant_next  = {1'b0, a_mant};
            small_exp_next = b_exp;
            small_mant_next = {1'b0, b_mant};
        end
        diff_next = big_exp_next - small_exp_next;
        if (diff_next >= 5'd12)
            small_mant_next = 12'd0;
        else
            small_mant_next = small_mant_next >> diff_next;
        count_next = count_reg + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_reg      <= IDLE;
            opnd_reg       <= 16'h0000;
            acc_reg        <= 16'h0000;
            result_reg     <= 16'h0000;
            count_reg      <= '0;
            done_reg       <= 1'b0;
            full_reg       <= 1'b0;
            v_reg          <= 1'b0;
            big_sign_reg   <= 1'b0;
            sub_reg        <= 1'b0;
            exp_reg        <= 6'd0;
            big_mant_reg   <= 12'd0;
            small_mant_reg <= 12'd0;
            sum_reg        <= 12'd0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (enable && !full_reg) begin
                        opnd_reg <= f_in;
                        if (v_in)
                            v_reg <= 1'b1;
                        state_reg <= ALIGN;
                    end
                end
                ALIGN: begin
                    big_sign_reg   <= big_sign_next;
                    sub_reg        <= acc_reg[15] ^ opnd_reg[15];
                    exp_reg        <= {1'b0, big_exp_next};
                    big_mant_reg   <= big_mant_next;
                    small_mant_reg <= small_mant_next;
                    state_reg      <= ADD;
                end
                ADD: begin
                    sum_reg   <= sub_reg ? big_mant_reg - small_mant_reg
                                         : big_mant_reg + small_mant_reg;
                    state_reg <= NORM;
                end
                NORM: begin
                    // One normalisation step per cycle; every exit goes to WRITE.
                    if (sum_reg[11]) begin
                        if (exp_reg >= 6'd30) begin
                            v_reg      <= 1'b1;
                            result_reg <= {big_sign_reg, 15'h7BFF};
                            state_reg  <= WRITE;
                        end else begin
                            sum_reg <= sum_reg >> 1;
                            exp_reg <= exp_reg + 6'd1;
                        end
                    end else if (sum_reg == 12'd0) begin
                        result_reg <= 16'h0000;
                        state_reg  <= WRITE;
                    end else if (!sum_reg[10]) begin
                        if (exp_reg <= 6'd1) begin
                            result_reg <= 16'h0000;
                            state_reg  <= WRITE;
                        end else begin
                            sum_reg <= sum_reg << 1;
                            exp_reg <= exp_reg - 6'd1;
                        end
                    end else begin
                        if (exp_reg > 6'd30) begin
                            v_reg      <= 1'b1;
                            result_reg <= {big_sign_reg, 15'h7BFF};
                        end else begin
                            result_reg <= {big_sign_reg, exp_reg[4:0], sum_reg[9:0]};
                        end
                        state_reg <= WRITE;
                    end
                end
                WRITE: begin
                    acc_reg   <= result_reg;
                    count_reg <= count_next;
                    done_reg  <= 1'b1;
                    if (count_next == CNT_W'(N_TERMS))
                        full_reg <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy  = (state_reg != IDLE);
    assign done  = done_reg;
    assign full  = full_reg;
    assign count = count_reg;
    assign acc   = acc_reg;
    assign v     = v_reg;

endmodule
